// File: rtl/aer_decoder.sv
// AER event decoder: buffers 39-bit address-event words in a small FIFO,
// presents the head event as decoded fields, counts delivered events and
// flags timestamps that go backwards.
//
// Handshake: a word moves across an interface on a rising edge exactly when
// its valid and ready are both high in that cycle. ready_o depends only on
// the registered fill level and valid_o only on the registered fill level,
// so neither has a combinational path from the opposite-side input.
//
// DEPTH must be a power of two and at least 2 so the pointers can wrap by
// plain binary overflow.
module aer_decoder #(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [38:0]                data_in_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  output logic [2:0]                 x_add_o,
  output logic [2:0]                 y_add_o,
  output logic [31:0]                timestamp_o,
  output logic                       polarity_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       ts_err_o,
  output logic [15:0]                event_count_o,
  input  logic                       count_clr_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  // FIFO storage and bookkeeping
  logic [38:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  // Timestamp monotonicity tracking
  logic [31:0]   last_ts_q, last_ts_d;
  logic          first_q, first_d;
  logic          ts_err_q, ts_err_d;

  // Delivered-event counter
  logic [15:0]   count_q, count_d;

  logic          push;
  logic          pop;
  logic [38:0]   head_word;
  logic [31:0]   in_ts;

  assign ready_o   = (level_q != FULL_LEVEL);
  assign valid_o   = (level_q != '0);
  assign push      = valid_i && ready_o;
  assign pop       = valid_o && ready_i;
  assign in_ts     = data_in_i[38:7];
  assign head_word = mem_q[rd_ptr_q];

  assign timestamp_o   = head_word[38:7];
  assign x_add_o       = head_word[6:4];
  assign y_add_o       = head_word[3:1];
  assign polarity_o    = head_word[0];
  assign level_o       = level_q;
  assign ts_err_o      = ts_err_q;
  assign event_count_o = count_q;

  // Next-state for pointers and fill level; a simultaneous push and pop
  // leaves the level unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Next-state for the timestamp checker; clear beats a same-cycle error.
  always_comb begin
    last_ts_d = last_ts_q;
    first_d   = first_q;
    ts_err_d  = ts_err_q;
    if (push) begin
      last_ts_d = in_ts;
      first_d   = 1'b0;
      if (!first_q && (in_ts < last_ts_q)) begin
        ts_err_d = 1'b1;
      end
    end
    if (count_clr_i) begin
      ts_err_d = 1'b0;
    end
  end

  // Next-state for the saturating delivery counter; clear beats a pop.
  always_comb begin
    count_d = count_q;
    if (count_clr_i) begin
      count_d = '0;
    end else if (pop && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  // Storage write at the tail; storage is zeroed on reset so the head
  // fields read 0 until the first word arrives.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= data_in_i;
    end
  end

  // Pointer and level registers; reset flushes everything immediately.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Timestamp checker registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_ts_q <= '0;
      first_q   <= 1'b1;
      ts_err_q  <= 1'b0;
    end else begin
      last_ts_q <= last_ts_d;
      first_q   <= first_d;
      ts_err_q  <= ts_err_d;
    end
  end

  // Delivery counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_aer_decoder.sv
// Bench for aer_decoder: directed scenarios plus a randomized phase, all
// compared against a queue-based reference of the decoder's behaviour.
module tb_aer_decoder;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [38:0]   data_in;
  logic          valid_in;
  logic          ready_out;
  logic [2:0]    x_add;
  logic [2:0]    y_add;
  logic [31:0]   ts_out;
  logic          pol_out;
  logic          valid_out;
  logic          ready_in;
  logic [LW-1:0] level;
  logic          ts_err;
  logic [15:0]   ev_cnt;
  logic          clr;

  aer_decoder #(.DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .data_in_i     (data_in),
    .valid_i       (valid_in),
    .ready_o       (ready_out),
    .x_add_o       (x_add),
    .y_add_o       (y_add),
    .timestamp_o   (ts_out),
    .polarity_o    (pol_out),
    .valid_o       (valid_out),
    .ready_i       (ready_in),
    .level_o       (level),
    .ts_err_o      (ts_err),
    .event_count_o (ev_cnt),
    .count_clr_i   (clr)
  );

  // ---------------- scoreboard / reference ----------------
  int checks = 0;
  int errors = 0;

  logic [38:0] exp_q[$];
  logic        m_ever;
  logic        m_have_last;
  logic [31:0] m_last_ts;
  logic        m_err;
  logic [15:0] m_cnt;

  task automatic model_reset();
    exp_q.delete();
    m_ever      = 1'b0;
    m_have_last = 1'b0;
    m_last_ts   = '0;
    m_err       = 1'b0;
    m_cnt       = '0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every visible output against the reference.
  task automatic check_all();
    logic [38:0] hw;
    chk("level",    64'(level),     64'(exp_q.size()));
    chk("valid_o",  64'(valid_out), 64'(exp_q.size() != 0));
    chk("ready_o",  64'(ready_out), 64'(exp_q.size() != DEPTH));
    chk("ts_err",   64'(ts_err),    64'(m_err));
    chk("ev_count", 64'(ev_cnt),    64'(m_cnt));
    if (exp_q.size() != 0 || !m_ever) begin
      hw = (exp_q.size() != 0) ? exp_q[0] : 39'd0;
      chk("head_ts",  64'(ts_out),  64'(hw[38:7]));
      chk("head_x",   64'(x_add),   64'(hw[6:4]));
      chk("head_y",   64'(y_add),   64'(hw[3:1]));
      chk("head_pol", 64'(pol_out), 64'(hw[0]));
    end
  endtask

  function automatic logic [38:0] mk(input logic [31:0] ts, input logic [2:0] x,
                                     input logic [2:0] y, input logic p);
    return {ts, x, y, p};
  endfunction

  // ---------------- driver ----------------
  // Called just after a falling edge: check, drive, advance one clock,
  // update the reference, return at the next falling edge.
  task automatic cycle(input logic v, input logic [38:0] d, input logic r, input logic c);
    logic acc, pp;
    logic [31:0] ts;
    check_all();
    valid_in = v;
    data_in  = d;
    ready_in = r;
    clr      = c;
    acc = v && (exp_q.size() != DEPTH);
    pp  = r && (exp_q.size() != 0);
    ts  = d[38:7];
    @(posedge clk);
    if (pp) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(d);
    if (c) m_err = 1'b0;
    else if (acc && m_have_last && (ts < m_last_ts)) m_err = 1'b1;
    if (acc) begin
      m_last_ts   = ts;
      m_have_last = 1'b1;
      m_ever      = 1'b1;
    end
    if (c) m_cnt = '0;
    else if (pp && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rts;
    rst_n    = 1'b0;
    data_in  = '0;
    valid_in = 1'b0;
    ready_in = 1'b0;
    clr      = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    // reset state, with input activity that must be ignored
    valid_in = 1'b1;
    data_in  = mk(32'h77, 3'd1, 3'd2, 1'b1);
    @(negedge clk);
    check_all();
    valid_in = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check_all();

    // single event
    cycle(1'b1, 39'h855, 1'b1, 1'b0);
    chk("single_valid", 64'(valid_out), 64'd1);
    chk("single_ts",    64'(ts_out),    64'h10);
    chk("single_x",     64'(x_add),     64'd5);
    chk("single_y",     64'(y_add),     64'd2);
    chk("single_pol",   64'(pol_out),   64'd1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("single_cnt",   64'(ev_cnt),    64'd1);
    chk("single_level", 64'(level),     64'd0);

    // fill and backpressure
    for (int i = 1; i <= 4; i++) cycle(1'b1, mk(32'(i), 3'(i), 3'(i), 1'b0), 1'b0, 1'b0);
    chk("full_ready", 64'(ready_out), 64'd0);
    chk("full_level", 64'(level),     64'd4);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, mk(32'd5, 3'd5, 3'd5, 1'b0), 1'b0, 1'b0);
      chk("stall_ts", 64'(ts_out), 64'd1);
    end
    cycle(1'b1, mk(32'd5, 3'd5, 3'd5, 1'b0), 1'b1, 1'b0);
    chk("pop_full_no_push", 64'(level), 64'd3);
    cycle(1'b1, mk(32'd5, 3'd5, 3'd5, 1'b0), 1'b1, 1'b0);
    for (int i = 3; i <= 5; i++) begin
      chk("drain_order", 64'(ts_out), 64'(i));
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    chk("drain_empty", 64'(valid_out), 64'd0);

    // continuous stream, pointers wrap several times
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, mk(32'(100 + i), 3'(i), 3'(i + 3), 1'(i)), 1'b1, 1'b0);
      chk("stream_level", 64'(level), 64'd1);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);

    // timestamp error
    cycle(1'b1, mk(32'h20, 3'd1, 3'd1, 1'b1), 1'b0, 1'b0);
    cycle(1'b1, mk(32'h1F, 3'd2, 3'd2, 1'b0), 1'b0, 1'b0);
    chk("ts_err_set", 64'(ts_err), 64'd1);
    cycle(1'b1, mk(32'h1F, 3'd3, 3'd3, 1'b1), 1'b1, 1'b0);
    chk("ts_err_sticky", 64'(ts_err), 64'd1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("clr_err", 64'(ts_err), 64'd0);
    chk("clr_cnt", 64'(ev_cnt), 64'd0);
    // error accept and clear in the same cycle: clear wins
    cycle(1'b1, mk(32'h05, 3'd0, 3'd0, 1'b0), 1'b0, 1'b1);
    chk("clr_beats_err", 64'(ts_err), 64'd0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // randomized traffic
    rts = 32'h1000;
    for (int i = 0; i < 3000; i++) begin
      rts = rts + 32'($urandom_range(0, 6)) - 32'd2;
      cycle(1'($urandom_range(0, 1)),
            mk(rts, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))),
            1'($urandom_range(0, 1)), ($urandom_range(0, 40) == 0));
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // counter saturation
    for (int i = 0; i < 65545; i++) cycle(1'b1, mk(32'h2000, 3'd1, 3'd1, 1'b1), 1'b1, 1'b0);
    chk("sat_cnt", 64'(ev_cnt), 64'hFFFF);
    cycle(1'b1, mk(32'h2000, 3'd1, 3'd1, 1'b1), 1'b1, 1'b1);
    chk("sat_clr_pop", 64'(ev_cnt), 64'd0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // reset mid-operation, not aligned to the clock
    for (int i = 0; i < 3; i++) cycle(1'b1, mk(32'(i + 50), 3'd6, 3'd6, 1'b1), 1'b0, 1'b0);
    chk("pre_rst_level", 64'(level), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_level", 64'(level),     64'd0);
    chk("rst_ready", 64'(ready_out), 64'd1);
    model_reset();
    ready_in = 1'b1;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      chk("no_stale", 64'(valid_out), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aer_decoder.md
AER_DECODER -- requirements
Module: aer_decoder

Interface
REQ-001 Parameter DEPTH, default 4, sets FIFO depth in 39-bit event words; SHALL be a power of 2, at least 2.
REQ-002 clk_i  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n_i  input  1  reset, asynchronous and active-low.
REQ-004 data_in_i  input  39  packed event word: [38:7] timestamp, [6:4] x address, [3:1] y address, [0] polarity.
REQ-005 valid_i  input  1  upstream has a word on data_in_i.
REQ-006 ready_o  output  1  decoder can accept a word this cycle.
REQ-007 x_add_o  output  3  row index of the head event.
REQ-008 y_add_o  output  3  column index of the head event.
REQ-009 timestamp_o  output  32  timestamp of the head event.
REQ-010 polarity_o  output  1  polarity of the head event.
REQ-011 valid_o  output  1  head event fields are valid.
REQ-012 ready_i  input  1  downstream accepts the head event this cycle.
REQ-013 level_o  output  $clog2(DEPTH)+1  number of words currently stored.
REQ-014 ts_err_o  output  1  sticky flag for a non-monotonic timestamp.
REQ-015 event_count_o  output  16  count of events delivered downstream.
REQ-016 count_clr_i  input  1  synchronous clear of event_count_o and ts_err_o.

Function
REQ-017 Accept SHALL occur when valid_i && ready_o; the word is written to the FIFO tail at that edge.
REQ-018 ready_o SHALL equal (level_o != DEPTH); push is refused when full, even if a pop happens in the same cycle.
REQ-019 valid_o SHALL equal (level_o != 0).
REQ-020 Output fields SHALL be combinational slices of the FIFO head word, per the bit mapping in REQ-004.
REQ-021 Pop SHALL occur when valid_o && ready_i; the head advances at that edge.
REQ-022 Latency: a word accepted at edge N into an empty FIFO SHALL show valid_o=1 with its fields in the cycle after edge N.
REQ-023 Ordering SHALL be strictly FIFO, with no loss and no duplication.
REQ-024 Push and pop in the same cycle (not full, not empty) SHALL leave level_o unchanged.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH.
REQ-026 While valid_o=1 and ready_i=0, all output fields SHALL stay stable.
REQ-027 Monotonic check: on each accept after the first since reset, compare the incoming timestamp with the last accepted timestamp.
REQ-028 If the incoming timestamp is less than the last accepted timestamp, ts_err_o SHALL be set at that edge.
REQ-029 Equal timestamps SHALL NOT set ts_err_o.
REQ-030 An event that sets ts_err_o SHALL still be stored and delivered.
REQ-031 ts_err_o SHALL stay set until count_clr_i=1 or reset.
REQ-032 If an error accept and count_clr_i=1 occur in the same cycle, clear SHALL win and ts_err_o = 0.
REQ-033 The last-accepted-timestamp register SHALL update on every accept.
REQ-034 event_count_o SHALL increment by 1 on each pop.
REQ-035 event_count_o SHALL saturate at 16'hFFFF.
REQ-036 count_clr_i=1 SHALL set event_count_o to 0 at that edge, and clear SHALL take priority over a same-cycle pop.
REQ-037 The block SHALL have no combinational path from valid_i to ready_o.
REQ-038 The block SHALL have no combinational path from ready_i to valid_o.

Reset
REQ-039 While rst_n_i=0, level_o=0, valid_o=0, ready_o=1, ts_err_o=0, event_count_o=0, pointers=0, and the first-event flag is set.
REQ-040 Output fields SHALL read 0 from reset until the first accept; FIFO storage SHALL be reset to 0.
REQ-041 Input activity while rst_n_i=0 SHALL be ignored.
REQ-042 Reset asserted mid-operation SHALL flush all stored words immediately, with no delivery after deassertion.

Verification
REQ-043 Single event: data_in_i=39'h855, valid_i for 1 cycle, ready_i=1 -> next cycle valid_o=1, timestamp_o=32'h10, x_add_o=5, y_add_o=2, polarity_o=1; after pop event_count_o=1 and level_o=0.
REQ-044 Fill and backpressure: DEPTH=4, ready_i=0, 5 consecutive valid_i words with timestamps 1..5 -> ready_o=0 after the 4th accept, level_o=4, 5th word held off, head timestamp_o=1 stable; with ready_i=1, outputs timestamps 1,2,3,4 then 5 in order.
REQ-045 Simultaneous push and pop: a continuous stream with valid_i=ready_i=1 for 20 cycles -> level_o stays 1, all 20 events delivered in order, and pointers wrap without error.
REQ-046 Timestamp error: accept ts=32'h20 then ts=32'h1F -> ts_err_o=1 after the second accept and remains 1; both events delivered; a following ts=32'h1F does not re-trigger; count_clr_i pulse -> ts_err_o=0, event_count_o=0.
REQ-047 Counter saturation: 65540 pops -> event_count_o=16'hFFFF; count_clr_i with a simultaneous pop -> event_count_o=0.
REQ-048 Reset mid-operation: 3 words stored, rst_n_i pulsed low asynchronously (not clock-aligned) -> valid_o=0, level_o=0, ready_o=1 immediately; no stale event appears after release.
